// File: rtl/ddc_pkg.sv
// Shared width helpers, default configuration and the IQ pair type for the
// down-converter.
package ddc_pkg;

   // Smallest w with 2**w >= value.
   function automatic int clog2_w(input int value);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < value) w = i + 1;
      return w;
   endfunction

   function automatic int prod_width(input int in_w, input int lo_w);
      return in_w + lo_w + 1;
   endfunction

   function automatic int acc_width(input int in_w, input int lo_w, input int r, input int n);
      return prod_width(in_w, lo_w) + n * clog2_w(r);
   endfunction

   function automatic int phase_width(input int r);
      return (clog2_w(r) < 1) ? 1 : clog2_w(r);
   endfunction

   localparam int DEF_IN_W  = 11;
   localparam int DEF_LO_W  = 11;
   localparam int DEF_R     = 30;
   localparam int DEF_N     = 3;
   localparam int DEF_OUT_W = 24;

   localparam int PROD_W = prod_width(DEF_IN_W, DEF_LO_W);
   localparam int ACC_W  = acc_width(DEF_IN_W, DEF_LO_W, DEF_R, DEF_N);

   typedef struct packed {
      logic signed [DEF_OUT_W-1:0] re;
      logic signed [DEF_OUT_W-1:0] im;
   } iq_t;

endpackage

// File: rtl/ddc_cic_chain.sv
// One rail of the CIC: N integrators on every accepted sample, a decimation
// tap, then N pipelined differential-delay-1 combs.
module ddc_cic_chain
   import ddc_pkg::*;
#(
   parameter int DIN_W = 23,
   parameter int AW    = 38,
   parameter int N     = 3
) (
   input  logic                 clk480,
   input  logic                 reset,
   input  logic                 ce,
   input  logic                 tap_en,
   input  logic [N-1:0]         comb_en,
   input  logic signed [DIN_W-1:0] din,
   output logic signed [AW-1:0] dout
);

   genvar gi;

   logic signed [AW-1:0] tap_reg;

   generate
      for (gi = 0; gi < N; gi++) begin : g_int
         logic signed [AW-1:0] acc_reg;
         logic signed [AW-1:0] acc_in;
         if (gi == 0) begin : g_first
            assign acc_in = AW'(din);
         end else begin : g_next
            assign acc_in = g_int[gi-1].acc_reg;
         end
         // Wrap-around is relied upon; the combs undo it exactly.
         always_ff @(posedge clk480) begin
            if (reset)
               acc_reg <= '0;
            else if (ce)
               acc_reg <= acc_reg + acc_in;
         end
      end
   endgenerate

   always_ff @(posedge clk480) begin
      if (reset)
         tap_reg <= '0;
      else if (tap_en)
         tap_reg <= g_int[N-1].acc_reg;
   end

   generate
      for (gi = 0; gi < N; gi++) begin : g_comb
         logic signed [AW-1:0] diff_reg;
         logic signed [AW-1:0] dly_reg;
         logic signed [AW-1:0] diff_in;
         if (gi == 0) begin : g_first
            assign diff_in = tap_reg;
         end else begin : g_next
            assign diff_in = g_comb[gi-1].diff_reg;
         end
         always_ff @(posedge clk480) begin
            if (reset) begin
               diff_reg <= '0;
               dly_reg  <= '0;
            end else if (comb_en[gi]) begin
               diff_reg <= diff_in - dly_reg;
               dly_reg  <= diff_in;
            end
         end
      end
   endgenerate

   assign dout = g_comb[N-1].diff_reg;

endmodule

// File: rtl/ddc_cic_decim.sv
// Complex mixer + N-stage CIC decimator by R. Define DDC_ROUND_EN for
// round-half-up with saturation at the output instead of floor truncation.
module ddc_cic_decim
   import ddc_pkg::*;
#(
   parameter int IN_W  = 11,
   parameter int LO_W  = 11,
   parameter int R     = 30,
   parameter int N     = 3,
   parameter int OUT_W = 24
) (
   input  logic                    clk480,
   input  logic                    reset,
   input  logic                    in_valid,
   input  logic                    sync,
   input  logic signed [IN_W-1:0]  sig_real,
   input  logic signed [IN_W-1:0]  sig_imag,
   input  logic signed [LO_W-1:0]  lo_real,
   input  logic signed [LO_W-1:0]  lo_imag,
   output logic signed [OUT_W-1:0] out_real,
   output logic signed [OUT_W-1:0] out_imag,
   output logic                    out_valid
);

   localparam int PW = prod_width(IN_W, LO_W);
   localparam int AW = acc_width(IN_W, LO_W, R, N);
   localparam int CW = phase_width(R);
   localparam int SH = AW - OUT_W;
   localparam int VW = 2 * N + 2;

   genvar gi;

   logic signed [PW-1:0]    mix_re_reg, mix_im_reg;
   logic signed [PW-1:0]    mix_re_next, mix_im_next;
   logic [CW-1:0]           phase_reg;
   logic [VW-1:0]           vld_reg;
   logic                    dec_now;
   logic                    tap_en;
   logic [N-1:0]            comb_en;
   logic signed [AW-1:0]    cic_re, cic_im;
   logic signed [OUT_W-1:0] out_re_next, out_im_next;

   function automatic logic signed [OUT_W-1:0] scale(input logic signed [AW-1:0] v);
`ifdef DDC_ROUND_EN
      localparam logic signed [AW:0] HALF   = (AW+1)'(1) << (SH - 1);
      localparam logic signed [AW:0] SAT_HI = {{(SH+2){1'b0}}, {(OUT_W-1){1'b1}}};
      localparam logic signed [AW:0] SAT_LO = ~SAT_HI;
      logic signed [AW:0] sum;
      logic signed [AW:0] q;
      sum = (AW+1)'(v) + HALF;
      q   = sum >>> SH;
      if (q > SAT_HI)
         return OUT_W'(SAT_HI);
      else if (q < SAT_LO)
         return OUT_W'(SAT_LO);
      return OUT_W'(q);
`else
      return OUT_W'(v >>> SH);
`endif
   endfunction

   always_comb begin
      mix_re_next = PW'(sig_real) * PW'(lo_real) - PW'(sig_imag) * PW'(lo_imag);
      mix_im_next = PW'(sig_real) * PW'(lo_imag) + PW'(sig_imag) * PW'(lo_real);
      // sync beats a coinciding decimation event.
      dec_now     = in_valid && !sync && (phase_reg == CW'(R - 1));
      out_re_next = scale(cic_re);
      out_im_next = scale(cic_im);
   end

   // vld_reg marks the decimated sample as it moves: [0] mixer, [1..N]
   // integrators, [N+1] tap, [N+2..2N+1] combs.
   assign tap_en = in_valid & vld_reg[N];

   generate
      for (gi = 0; gi < N; gi++) begin : g_en
         assign comb_en[gi] = in_valid & vld_reg[N+1+gi];
      end
   endgenerate

   always_ff @(posedge clk480) begin
      if (reset) begin
         mix_re_reg <= '0;
         mix_im_reg <= '0;
         phase_reg  <= '0;
         vld_reg    <= '0;
         out_real   <= '0;
         out_imag   <= '0;
         out_valid  <= 1'b0;
      end else begin
         if (sync)
            phase_reg <= '0;
         else if (in_valid)
            phase_reg <= dec_now ? '0 : phase_reg + CW'(1);
         if (in_valid) begin
            mix_re_reg <= mix_re_next;
            mix_im_reg <= mix_im_next;
            vld_reg    <= {vld_reg[VW-2:0], dec_now};
         end
         out_valid <= in_valid & vld_reg[VW-1];
         if (in_valid && vld_reg[VW-1]) begin
            out_real <= out_re_next;
            out_imag <= out_im_next;
         end
      end
   end

   ddc_cic_chain #(.DIN_W(PW), .AW(AW), .N(N)) u_chain_i (
      .clk480  (clk480),
      .reset   (reset),
      .ce      (in_valid),
      .tap_en  (tap_en),
      .comb_en (comb_en),
      .din     (mix_re_reg),
      .dout    (cic_re)
   );

   ddc_cic_chain #(.DIN_W(PW), .AW(AW), .N(N)) u_chain_q (
      .clk480  (clk480),
      .reset   (reset),
      .ce      (in_valid),
      .tap_en  (tap_en),
      .comb_en (comb_en),
      .din     (mix_im_reg),
      .dout    (cic_im)
   );

endmodule
